// File: rtl/quant_matrix_loader_if.sv
// ---------------------------------------------------------------------------
// quant_matrix_loader_if
//
// Purpose: bundles every non-clock, non-reset signal of the quantiser matrix
// loader. It carries the upload control (start, matrix_sel, rst_req), the
// byte stream handshake (in_valid, in_data, in_ready), the matrix write port
// (wr_addr, wr_dta, wr_clk_en, intra_wr_en, non_intra_wr_en, rst_values) and
// the status outputs (busy, done, zero_err).
//
// Modports:
//   slave  - the loader's view: control and stream inputs, write/status outputs
//   master - the view of whatever drives the loader (decoder or bench)
// ---------------------------------------------------------------------------
interface quant_matrix_loader_if;
    logic       start;
    logic       matrix_sel;
    logic       rst_req;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [5:0] wr_addr;
    logic [7:0] wr_dta;
    logic       wr_clk_en;
    logic       intra_wr_en;
    logic       non_intra_wr_en;
    logic       rst_values;
    logic       busy;
    logic       done;
    logic       zero_err;

    modport slave (
        input  start, matrix_sel, rst_req, in_valid, in_data,
        output in_ready, wr_addr, wr_dta, wr_clk_en, intra_wr_en,
               non_intra_wr_en, rst_values, busy, done, zero_err
    );

    modport master (
        output start, matrix_sel, rst_req, in_valid, in_data,
        input  in_ready, wr_addr, wr_dta, wr_clk_en, intra_wr_en,
               non_intra_wr_en, rst_values, busy, done, zero_err
    );
endinterface

// File: rtl/quant_matrix_loader.sv
// ---------------------------------------------------------------------------
// quant_matrix_loader
//
// Purpose: receives the 64 values of an MPEG quantiser matrix in transmitted
// (zigzag) order and turns each accepted byte into one write on the matrix
// write port, one cycle later. A restore-defaults request (rst_req) aborts
// any upload and issues a single rst_values strobe to both matrices.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - quant_matrix_loader_if.slave:
//            start/matrix_sel   begin an upload into intra (0) / non-intra (1)
//            rst_req            restore both matrices to default values
//            in_valid/in_data   byte stream, in_ready high only while loading
//            wr_*               registered matrix write port
//            rst_values         restore strobe, qualified by wr_clk_en
//            busy/done          upload status, done pulses with write 63
//            zero_err           pulses with the write of a zero byte
//
// Configuration macro:
//   QUANT_LOADER_ZERO_CHECK_EN - when defined, a received 8'h00 (illegal as a
//   quantiser value) is written as 8'h01 and flagged on zero_err. When
//   undefined, data passes unmodified and zero_err stays 0.
// ---------------------------------------------------------------------------
module quant_matrix_loader (
    input  logic                 clk,
    input  logic                 rst,
    quant_matrix_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        LOAD = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [5:0] count;
    logic       sel_q;

    logic [5:0] wr_addr_q;
    logic [7:0] wr_dta_q;
    logic       wr_clk_en_q;
    logic       intra_wr_en_q;
    logic       non_intra_wr_en_q;
    logic       rst_values_q;
    logic       zero_err_q;

    logic       accept;
    logic       load_entry;
    logic       last_byte;
    logic       data_is_zero;
    logic [7:0] write_data;

    assign accept     = bus.in_valid && (state == LOAD);
    assign load_entry = (state == IDLE) && bus.start && !bus.rst_req;
    assign last_byte  = accept && (count == 6'd63);

`ifdef QUANT_LOADER_ZERO_CHECK_EN
    // Zero is not a legal quantiser value; substitute the smallest legal one.
    assign data_is_zero = (bus.in_data == 8'h00);
    assign write_data   = data_is_zero ? 8'h01 : bus.in_data;
`else
    assign data_is_zero = 1'b0;
    assign write_data   = bus.in_data;
`endif

    // State register. The restore request always wins, so the next-state
    // logic below already folds it in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start is only looked at in IDLE, and DONE lasts
    // exactly one cycle so the done pulse lines up with write 63.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    if (last_byte) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.rst_req) begin
            state_next = IDLE;
        end
    end

    // Position counter and latched target matrix. The counter holds at 63
    // on the final byte instead of wrapping, since LOAD is left right there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 6'd0;
            sel_q <= 1'b0;
        end else begin
            if (bus.rst_req || load_entry) begin
                count <= 6'd0;
            end else if (accept && (count != 6'd63)) begin
                count <= count + 6'd1;
            end
            if (load_entry) begin
                sel_q <= bus.matrix_sel;
            end
        end
    end

    // Registered write port. Strobes default low every cycle while address
    // and data hold. A restore request discards a byte accepted alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q         <= 6'd0;
            wr_dta_q          <= 8'd0;
            wr_clk_en_q       <= 1'b0;
            intra_wr_en_q     <= 1'b0;
            non_intra_wr_en_q <= 1'b0;
            rst_values_q      <= 1'b0;
            zero_err_q        <= 1'b0;
        end else begin
            wr_clk_en_q       <= 1'b0;
            intra_wr_en_q     <= 1'b0;
            non_intra_wr_en_q <= 1'b0;
            rst_values_q      <= 1'b0;
            zero_err_q        <= 1'b0;
            if (bus.rst_req) begin
                wr_clk_en_q  <= 1'b1;
                rst_values_q <= 1'b1;
            end else if (accept) begin
                wr_clk_en_q       <= 1'b1;
                wr_addr_q         <= count;
                wr_dta_q          <= write_data;
                intra_wr_en_q     <= !sel_q;
                non_intra_wr_en_q <= sel_q;
                zero_err_q        <= data_is_zero;
            end
        end
    end

    assign bus.in_ready        = (state == LOAD);
    assign bus.busy            = (state == LOAD) || (state == DONE);
    assign bus.done            = (state == DONE);
    assign bus.wr_addr         = wr_addr_q;
    assign bus.wr_dta          = wr_dta_q;
    assign bus.wr_clk_en       = wr_clk_en_q;
    assign bus.intra_wr_en     = intra_wr_en_q;
    assign bus.non_intra_wr_en = non_intra_wr_en_q;
    assign bus.rst_values      = rst_values_q;
    assign bus.zero_err        = zero_err_q;

endmodule

// File: tb/tb_quant_matrix_loader.sv
// ---------------------------------------------------------------------------
// tb_quant_matrix_loader
//
// Purpose: self-checking bench for quant_matrix_loader. A behavioural model
// tracks "loading / finishing" and the byte position, and predicts every
// output for each cycle; a compare process checks the DUT at each falling
// edge. Directed scenarios (intra load, backpressure, abort, collision,
// zero byte, asynchronous reset) add literal expectations, followed by a
// randomized run. Honours QUANT_LOADER_ZERO_CHECK_EN like the design.
// ---------------------------------------------------------------------------
module tb_quant_matrix_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;

    quant_matrix_loader_if bus ();

    quant_matrix_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state and predicted outputs
    bit         m_loading   = 1'b0;
    bit         m_finishing = 1'b0;
    bit         m_sel       = 1'b0;
    int         m_pos       = 0;
    logic [5:0] e_addr      = '0;
    logic [7:0] e_dta       = '0;
    logic       e_wce       = 1'b0;
    logic       e_intra     = 1'b0;
    logic       e_non       = 1'b0;
    logic       e_rstv      = 1'b0;
    logic       e_zero      = 1'b0;

    // Scenario monitor counters
    int         wr_cnt, intra_cnt, non_cnt, done_cnt, rstv_cnt, zero_cnt;
    int         first_addr, done_addr, done_dta, addr5_dta, addr5_zero;

    function automatic logic [7:0] expData(input logic [7:0] d);
`ifdef QUANT_LOADER_ZERO_CHECK_EN
        return (d == 8'h00) ? 8'h01 : d;
`else
        return d;
`endif
    endfunction

    function automatic logic expZero(input logic [7:0] d);
`ifdef QUANT_LOADER_ZERO_CHECK_EN
        return (d == 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // One call = one cycle of inputs, applied shortly after a rising edge
    task automatic applyStimulus(input logic s, input logic sel, input logic rq,
                                 input logic v, input logic [7:0] d);
        @(posedge clk);
        #2;
        bus.start      = s;
        bus.matrix_sel = sel;
        bus.rst_req    = rq;
        bus.in_valid   = v;
        bus.in_data    = d;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic clearCounters();
        wr_cnt = 0; intra_cnt = 0; non_cnt = 0; done_cnt = 0; rstv_cnt = 0;
        zero_cnt = 0; first_addr = -1; done_addr = -1; done_dta = -1;
        addr5_dta = -1; addr5_zero = -1;
    endtask

    // Behavioural model: what the outputs must be after each rising edge
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_loading = 0; m_finishing = 0; m_sel = 0; m_pos = 0;
                e_addr = '0; e_dta = '0; e_wce = 0; e_intra = 0; e_non = 0;
                e_rstv = 0; e_zero = 0;
            end else begin
                e_wce = 0; e_intra = 0; e_non = 0; e_rstv = 0; e_zero = 0;
                if (bus.rst_req) begin
                    e_wce = 1; e_rstv = 1;
                    m_loading = 0; m_finishing = 0;
                end else if (m_loading) begin
                    if (bus.in_valid) begin
                        e_wce   = 1;
                        e_addr  = m_pos[5:0];
                        e_dta   = expData(bus.in_data);
                        e_zero  = expZero(bus.in_data);
                        e_intra = !m_sel;
                        e_non   = m_sel;
                        m_pos++;
                        if (m_pos == 64) begin
                            m_loading   = 0;
                            m_finishing = 1;
                        end
                    end
                end else if (m_finishing) begin
                    m_finishing = 0;
                end else if (bus.start) begin
                    m_loading = 1;
                    m_pos     = 0;
                    m_sel     = bus.matrix_sel;
                end
            end
        end
    end

    // Compare process plus scenario monitor, on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("in_ready", int'(bus.in_ready), int'(m_loading));
            checkOutput("busy", int'(bus.busy), int'(m_loading || m_finishing));
            checkOutput("done", int'(bus.done), int'(m_finishing));
            checkOutput("wr_addr", int'(bus.wr_addr), int'(e_addr));
            checkOutput("wr_dta", int'(bus.wr_dta), int'(e_dta));
            checkOutput("wr_clk_en", int'(bus.wr_clk_en), int'(e_wce));
            checkOutput("intra_wr_en", int'(bus.intra_wr_en), int'(e_intra));
            checkOutput("non_intra_wr_en", int'(bus.non_intra_wr_en), int'(e_non));
            checkOutput("rst_values", int'(bus.rst_values), int'(e_rstv));
            checkOutput("zero_err", int'(bus.zero_err), int'(e_zero));
            if (bus.wr_clk_en && (bus.intra_wr_en || bus.non_intra_wr_en)) begin
                if (wr_cnt == 0) first_addr = int'(bus.wr_addr);
                wr_cnt++;
                if (bus.intra_wr_en) intra_cnt++;
                if (bus.non_intra_wr_en) non_cnt++;
                if (bus.wr_addr == 6'd5) begin
                    addr5_dta  = int'(bus.wr_dta);
                    addr5_zero = int'(bus.zero_err);
                end
            end
            if (bus.zero_err) zero_cnt++;
            if (bus.wr_clk_en && bus.rst_values) rstv_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_addr = int'(bus.wr_addr);
                done_dta  = int'(bus.wr_dta);
            end
        end
    end

    initial begin
        bus.start = 0; bus.matrix_sel = 0; bus.rst_req = 0; bus.in_valid = 0; bus.in_data = 0;
        clearCounters();

        // Reset state
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_in_ready", int'(bus.in_ready), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_wr_clk_en", int'(bus.wr_clk_en), 0);
        checkOutput("reset_rst_values", int'(bus.rst_values), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Intra load, bytes 1..64 back to back
        $display("[TB] intra load");
        clearCounters();
        applyStimulus(1, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 64; i++) applyStimulus(0, 0, 0, 1, 8'(i));
        idleCycles(3);
        checkOutput("intra_writes", intra_cnt, 64);
        checkOutput("intra_non_writes", non_cnt, 0);
        checkOutput("intra_first_addr", first_addr, 0);
        checkOutput("intra_done_count", done_cnt, 1);
        checkOutput("intra_done_addr", done_addr, 63);
        checkOutput("intra_done_data", done_dta, 64);

        // Non-intra load with valid toggling
        $display("[TB] backpressure");
        clearCounters();
        applyStimulus(1, 1, 0, 0, 8'h00);
        for (int i = 0; i < 128; i++) applyStimulus(0, 0, 0, (i % 2) == 0, 8'(i + 1));
        idleCycles(3);
        checkOutput("bp_non_writes", non_cnt, 64);
        checkOutput("bp_intra_writes", intra_cnt, 0);
        checkOutput("bp_done_count", done_cnt, 1);
        checkOutput("bp_done_addr", done_addr, 63);

        // Abort after 10 bytes; byte sent with rst_req is dropped
        $display("[TB] abort");
        clearCounters();
        applyStimulus(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 8'(i + 20));
        applyStimulus(0, 0, 1, 1, 8'h77);
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("abort_wr_clk_en", int'(bus.wr_clk_en), 1);
        checkOutput("abort_rst_values", int'(bus.rst_values), 1);
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_intra_wr_en", int'(bus.intra_wr_en), 0);
        idleCycles(3);
        checkOutput("abort_writes", wr_cnt, 10);
        checkOutput("abort_done_count", done_cnt, 0);
        clearCounters();
        applyStimulus(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 64; i++) applyStimulus(0, 0, 0, 1, 8'($urandom_range(1, 255)));
        idleCycles(3);
        checkOutput("restart_first_addr", first_addr, 0);
        checkOutput("restart_writes", wr_cnt, 64);
        checkOutput("restart_done_count", done_cnt, 1);

        // start and rst_req together
        $display("[TB] collision");
        clearCounters();
        applyStimulus(1, 1, 1, 0, 8'h00);
        applyStimulus(0, 0, 0, 1, 8'h11);
        checkOutput("coll_rst_values", int'(bus.rst_values), 1);
        checkOutput("coll_in_ready", int'(bus.in_ready), 0);
        applyStimulus(0, 0, 0, 1, 8'h12);
        checkOutput("coll_busy", int'(bus.busy), 0);
        checkOutput("coll_in_ready_later", int'(bus.in_ready), 0);
        idleCycles(3);
        checkOutput("coll_writes", wr_cnt, 0);
        checkOutput("coll_rstv_count", rstv_cnt, 1);

        // Zero byte at position 5
        $display("[TB] zero byte");
        clearCounters();
        applyStimulus(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 64; i++) applyStimulus(0, 0, 0, 1, (i == 5) ? 8'h00 : 8'(i + 1));
        idleCycles(3);
`ifdef QUANT_LOADER_ZERO_CHECK_EN
        checkOutput("zero_addr5_data", addr5_dta, 1);
        checkOutput("zero_addr5_flag", addr5_zero, 1);
        checkOutput("zero_flag_count", zero_cnt, 1);
`else
        checkOutput("zero_addr5_data", addr5_dta, 0);
        checkOutput("zero_addr5_flag", addr5_zero, 0);
        checkOutput("zero_flag_count", zero_cnt, 0);
`endif

        // Asynchronous reset between clock edges in the middle of a load
        $display("[TB] async reset");
        applyStimulus(1, 1, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 8'(i + 100));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_in_ready", int'(bus.in_ready), 0);
        checkOutput("arst_busy", int'(bus.busy), 0);
        checkOutput("arst_wr_clk_en", int'(bus.wr_clk_en), 0);
        checkOutput("arst_non_intra_wr_en", int'(bus.non_intra_wr_en), 0);
        checkOutput("arst_wr_addr", int'(bus.wr_addr), 0);
        checkOutput("arst_wr_dta", int'(bus.wr_dta), 0);
        @(negedge clk);
        rst = 1'b0;
        clearCounters();
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 8'h55);
        idleCycles(2);
        checkOutput("arst_writes_after", wr_cnt, 0);

        // Randomized traffic
        $display("[TB] random");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
        end
        idleCycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
